// File: rtl/ysyx_220066_pkg.sv
// Shared types and constants for the ysyx_220066 instruction fetch unit.
package ysyx_220066_pkg;

   localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   // One decoded-side buffer entry: fetch PC, instruction word, fault flag.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        fault;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // Faulting entries always carry a nop so decode never sees garbage.
   function automatic entry_t make_entry(input logic [63:0] pc,
                                         input logic [31:0] data,
                                         input logic        err);
      entry_t e;
      e.pc    = pc;
      e.instr = err ? NOP_INSTR : data;
      e.fault = err;
      return e;
   endfunction

endpackage

// File: rtl/ysyx_220066_ifu_if.sv
// Fetch-unit bus bundle: memory request/response, decode handoff, redirect/halt control.
interface ysyx_220066_ifu_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;

   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [63:0] id_pc;
   logic        id_fault;

   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt;

   // The fetch unit side.
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      output id_valid, id_instr, id_pc, id_fault,
      input  id_ready, redirect_valid, redirect_pc, halt
   );

   // The surrounding core / memory side.
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      input  id_valid, id_instr, id_pc, id_fault,
      output id_ready, redirect_valid, redirect_pc, halt
   );

endinterface

// File: rtl/ysyx_220066_ifu_fifo.sv
// Small synchronous FIFO with flush; used for the in-flight PC queue and the instruction buffer.
module ysyx_220066_ifu_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full;
   logic             empty;

   assign count_o = wr_q - rd_q;
   assign full    = (count_o == (AW+1)'(DEPTH));
   assign empty   = (count_o == '0);
   assign head_o  = mem_q[rd_q[AW-1:0]];

   // Pointer update; flush wins over push and pop.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_i && !full) wr_d = wr_q + (AW+1)'(1);
         if (pop_i && !empty) rd_d = rd_q + (AW+1)'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage is data only and is not reset.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i && !full) mem_q[wr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/ysyx_220066_ifu.sv
// Instruction fetch unit: issues aligned 32-bit reads, buffers {pc, instr, fault}
// for decode, drops stale responses after a redirect and reports fetch faults.
module ysyx_220066_ifu
   import ysyx_220066_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   ysyx_220066_ifu_if.master  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]    drop_q, drop_d;
   logic             stopped_q, stopped_d;

   // The PC queue occupancy is exactly the number of unanswered requests.
   logic [CW-1:0]    outstanding;
   logic [63:0]      pc_head;
   logic [CW-1:0]    buf_cnt;
   logic [ENTRY_W-1:0] buf_head_raw;
   entry_t           buf_head;
   entry_t           buf_din;

   logic [CW:0]      credit_sum;
   logic             credit_ok;
   logic             aligned;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_live;
   logic             mis_push;
   logic             buf_push;
   logic             buf_pop;
   logic             id_valid;

   assign credit_sum = {1'b0, outstanding} + {1'b0, buf_cnt};
   assign credit_ok  = (credit_sum < (CW+1)'(DEPTH));
   assign aligned    = (fetch_pc_q[1:0] == 2'b00);
   assign req_valid  = !rst && !bus.redirect_valid && !bus.halt && !stopped_q
                       && aligned && credit_ok;
   assign req_fire   = req_valid && bus.imem_req_ready;

   // A response is kept only if it belongs to the current fetch stream.
   assign rsp_live   = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0);
   // Misaligned target: emit one fault entry once the stale stream has drained.
   assign mis_push   = !bus.redirect_valid && !stopped_q && !aligned
                       && (drop_q == '0) && (buf_cnt != CW'(DEPTH));
   assign buf_push   = rsp_live || mis_push;
   assign buf_din    = rsp_live ? make_entry(pc_head, bus.imem_rsp_data, bus.imem_rsp_err)
                                : make_entry(fetch_pc_q, NOP_INSTR, 1'b1);

   assign id_valid   = (buf_cnt != '0);
   assign buf_pop    = id_valid && bus.id_ready;
   assign buf_head   = entry_t'(buf_head_raw);

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = {fetch_pc_q[63:2], 2'b00};
   assign bus.id_valid       = id_valid;
   assign bus.id_pc          = id_valid ? buf_head.pc    : 64'd0;
   assign bus.id_instr       = id_valid ? buf_head.instr : NOP_INSTR;
   assign bus.id_fault       = id_valid && buf_head.fault;

   ysyx_220066_ifu_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_pc_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (1'b0),
      .push_i      (req_fire),
      .push_data_i (fetch_pc_q),
      .pop_i       (bus.imem_rsp_valid),
      .head_o      (pc_head),
      .count_o     (outstanding)
   );

   ysyx_220066_ifu_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_ibuf (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (bus.redirect_valid),
      .push_i      (buf_push),
      .push_data_i (buf_din),
      .pop_i       (buf_pop),
      .head_o      (buf_head_raw),
      .count_o     (buf_cnt)
   );

   // Next fetch PC, stale-response count and stop flag; redirect has priority.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      stopped_d  = stopped_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
         drop_d     = outstanding - CW'(bus.imem_rsp_valid);
         stopped_d  = 1'b0;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
         if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
         if ((rsp_live && bus.imem_rsp_err) || mis_push) stopped_d = 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
         stopped_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
         stopped_q  <= stopped_d;
      end
   end

endmodule
